dmem_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time on the MemRead/MemWrite/addr/wr_data/func3 interface driven from the EX/MEM stage. It inserts a configurable number of wait states, signalled to the pipeline through `busy`. It performs byte/halfword/word accesses on a word-organised array, returning sign- or zero-extended load data with a one-cycle `rd_valid` pulse.

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_responder_lane_align.sv | 56 +++++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: func3 access encodings and FSM states.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated store word,
// sign/zero-extended load data, and misalignment / reserved-encoding detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic        store,
  input  logic [31:0] st_data,
  input  logic [31:0] word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word,
  output logic [31:0] ld_data,
  output logic        err
);

  logic [31:0] shifted;

  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    byte_en = '0;
    st_word = '0;
    ld_data = '0;
    err     = 1'b0;
    case (func3)
      F3_B, F3_BU: begin
        byte_en = 4'b0001 << lane;
        st_word = {4{st_data[7:0]}};
        ld_data = (func3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                  : {24'b0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        err     = lane[0];
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
        ld_data = (func3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                  : {16'b0, shifted[15:0]};
      end
      F3_W: begin
        err     = (lane != 2'b00);
        byte_en = '1;
        st_word = st_data;
        ld_data = word;
      end
      default: err = 1'b1;
    endcase
    // Stores have no unsigned variants, so any func3 with bit 2 set is reserved.
    if (store && func3[2]) err = 1'b1;
    if (err) begin
      byte_en = '0;
      ld_data = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_STATES wait cycles, then
// a byte/half/word access on a word-organised array with a registered ack.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  ack,
  output logic                  busy,
  output logic                  misaligned
);

  localparam int unsigned WORDS = 1 << (DM_ADDRESS - 2);

  dmem_state_t state, next_state;
  logic [2:0]  cnt, cnt_next;

  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [2:0]            f3_q;
  logic                  store_q;

  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] word;

  logic        latch_req, do_access;
  logic [3:0]  byte_en;
  logic [31:0] st_word, ld_data;
  logic        err;

  assign word = mem[addr_q[DM_ADDRESS-1:2]];

  dmem_lane_align u_align (
    .func3   (f3_q),
    .lane    (addr_q[1:0]),
    .store   (store_q),
    .st_data (data_q),
    .word    (word),
    .byte_en (byte_en),
    .st_word (st_word),
    .ld_data (ld_data),
    .err     (err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      rd_valid   <= 1'b0;
      misaligned <= 1'b0;
      rd_data    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      f3_q       <= '0;
      store_q    <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      busy       <= (next_state != IDLE);
      ack        <= do_access;
      rd_valid   <= do_access && !store_q;
      misaligned <= do_access && err;
      if (do_access && !store_q) rd_data <= ld_data;
      if (latch_req) begin
        addr_q  <= addr;
        data_q  <= wr_data;
        f3_q    <= func3;
        store_q <= MemWrite;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (WAIT_STATES == 0) begin
            next_state = ACCESS;
          end else begin
            next_state = WAIT;
            cnt_next   = 3'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 3'd1;
        if (cnt == 3'd1) next_state = ACCESS;
      end
      ACCESS:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    latch_req = (state == IDLE) && (MemRead || MemWrite);
    do_access = (state == ACCESS);
  end

  // Array has no reset; an async reset forces IDLE, which blocks any pending write.
  always_ff @(posedge clk) begin
    if (do_access && store_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[addr_q[DM_ADDRESS-1:2]][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct packed {
    logic        is_load;
    logic        mis;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, mr, mw, rv, ak, bz, mis;
  logic [1:0][8:0]  ad;
  logic [1:0][31:0] wd, rdd;
  logic [1:0][2:0]  f3;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(rst[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]),
    .wr_data(wd[0]), .func3(f3[0]), .rd_data(rdd[0]), .rd_valid(rv[0]), .ack(ak[0]),
    .busy(bz[0]), .misaligned(mis[0])
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(rst[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]),
    .wr_data(wd[1]), .func3(f3[1]), .rd_data(rdd[1]), .rd_valid(rv[1]), .ack(ak[1]),
    .busy(bz[1]), .misaligned(mis[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response for that instance.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rv[d] === 1'b1 && ak[d] !== 1'b1) begin
        checks++; errors++;
        $display("FAIL rd_valid_without_ack dut%0d: got rd_valid=1 ack=%b expected ack=1", d, ak[d]);
      end
      if (ak[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          checks++; errors++;
          $display("FAIL unexpected_ack dut%0d: got ack=1 expected no ack", d);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("resp_rd_valid", 32'(rv[d]), 32'(e.is_load));
          chk("resp_misaligned", 32'(mis[d]), 32'(e.mis));
          if (e.is_load) chk("resp_rd_data", rdd[d], e.data);
        end
      end
    end
  end

  task automatic drive(input int d, input bit junk);
    if (junk) begin
      mr[d] = 1'b1; mw[d] = 1'b1; ad[d] = 9'h020; wd[d] = 32'hFFFF_FFFF; f3[d] = F3_W;
    end else begin
      mr[d] = 1'b0; mw[d] = 1'b0;
    end
  endtask

  task automatic req(input int d, input logic r, input logic w, input logic [8:0] a,
                     input logic [31:0] data, input logic [2:0] f, input logic exp_mis,
                     input logic [31:0] exp_data, input bit toggle);
    exp_t e;
    int   n, wst;
    bit   got;
    wst = (d == 0) ? 2 : 0;
    e.is_load = !w;
    e.mis     = exp_mis;
    e.data    = exp_data;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk); #1;
    mr[d] = r; mw[d] = w; ad[d] = a; wd[d] = data; f3[d] = f;
    @(posedge clk); #1;
    n = 1; got = 0;
    drive(d, toggle && n <= wst);
    while (!got && n <= wst + 4) begin
      @(negedge clk);
      if (ak[d] === 1'b1) begin
        got = 1;
        chk("ack_latency", 32'(n), 32'(wst + 2));
        chk("busy_low_at_ack", 32'(bz[d]), 32'd0);
      end else begin
        if (n <= wst + 1) chk("busy_high", 32'(bz[d]), 32'd1);
        @(posedge clk); #1;
        n++;
        drive(d, toggle && n <= wst);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout dut%0d: got no ack after %0d cycles expected ack at %0d", d, n, wst + 2);
    end
  endtask

  task automatic abort_store(input int d, input logic [8:0] a, input logic [31:0] data);
    @(posedge clk); #1;
    mw[d] = 1'b1; mr[d] = 1'b0; ad[d] = a; wd[d] = data; f3[d] = F3_W;
    @(posedge clk); #1;
    drive(d, 1'b0);
    rst[d] = 1'b0;
    @(posedge clk); #1;
    rst[d] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ak[d]), 32'd0);
    end
    chk("abort_busy_low", 32'(bz[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = '0; mr = '0; mw = '0; ad = '0; wd = '0; f3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b11;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rd_data", rdd[d], 32'd0);
      chk("reset_rd_valid", 32'(rv[d]), 32'd0);
      chk("reset_ack", 32'(ak[d]), 32'd0);
      chk("reset_busy", 32'(bz[d]), 32'd0);
      chk("reset_misaligned", 32'(mis[d]), 32'd0);
    end

    req(0, 0, 1, 9'h010, 32'hDEAD_BEEF, F3_W,  0, 32'h0,         0);
    req(0, 1, 0, 9'h010, 32'h0,         F3_W,  0, 32'hDEAD_BEEF, 0);
    req(0, 0, 1, 9'h012, 32'h0000_007F, F3_B,  0, 32'h0,         0);
    req(0, 1, 0, 9'h013, 32'h0,         F3_B,  0, 32'hFFFF_FFDE, 0);
    req(0, 1, 0, 9'h013, 32'h0,         F3_BU, 0, 32'h0000_00DE, 0);
    req(0, 1, 0, 9'h010, 32'h0,         F3_W,  0, 32'hDE7F_BEEF, 0);
    req(0, 1, 0, 9'h011, 32'h0,         F3_H,  1, 32'h0,         0);
    req(0, 0, 1, 9'h012, 32'h1111_1111, F3_W,  1, 32'h0,         0);
    req(0, 1, 0, 9'h010, 32'h0,         F3_W,  0, 32'hDE7F_BEEF, 0);
    req(0, 1, 0, 9'h012, 32'h0,         F3_HU, 0, 32'h0000_DE7F, 0);
    req(0, 1, 0, 9'h012, 32'h0,         F3_H,  0, 32'hFFFF_DE7F, 0);
    req(0, 0, 1, 9'h010, 32'hABCD_1234, F3_H,  0, 32'h0,         0);
    req(0, 1, 0, 9'h010, 32'h0,         F3_H,  0, 32'h0000_1234, 0);
    req(0, 1, 0, 9'h010, 32'h0,         3'b011, 1, 32'h0,        0);
    req(0, 0, 1, 9'h010, 32'h5555_5555, F3_BU, 1, 32'h0,         0);
    req(0, 1, 0, 9'h010, 32'h0,         F3_W,  0, 32'hDE7F_1234, 0);
    req(0, 0, 1, 9'h1FF, 32'h0000_0080, F3_B,  0, 32'h0,         0);
    req(0, 1, 0, 9'h1FF, 32'h0,         F3_B,  0, 32'hFFFF_FF80, 0);
    req(0, 1, 0, 9'h1FF, 32'h0,         F3_BU, 0, 32'h0000_0080, 0);
    req(0, 1, 1, 9'h020, 32'h1234_5678, F3_W,  0, 32'h0,         1);
    req(0, 1, 0, 9'h020, 32'h0,         F3_W,  0, 32'h1234_5678, 0);
    abort_store(0, 9'h020, 32'hAAAA_AAAA);
    req(0, 1, 0, 9'h020, 32'h0,         F3_W,  0, 32'h1234_5678, 0);

    req(1, 0, 1, 9'h004, 32'hCAFE_F00D, F3_W,  0, 32'h0,         0);
    req(1, 1, 0, 9'h004, 32'h0,         F3_W,  0, 32'hCAFE_F00D, 0);
    req(1, 1, 0, 9'h006, 32'h0,         F3_HU, 0, 32'h0000_CAFE, 0);
    abort_store(1, 9'h004, 32'h5555_5555);
    req(1, 1, 0, 9'h004, 32'h0,         F3_W,  0, 32'hCAFE_F00D, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
